// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter. Build option: RAM_ARB_ALIGN_CHECK_EN
// (reject misaligned word accesses with err).
package ram_arb_pkg;
  localparam int RAM_G      = 18;
  localparam int DW         = 32;
  localparam int WORD_BYTES = 4;
  localparam int NUM_PORTS  = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

  typedef logic port_id_t;

  typedef struct packed {
    logic             we;
    logic             bmode;
    logic [RAM_G-1:0] addr;
    logic [DW-1:0]    wdata;
  } ram_req_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester ports and RAM-side bus of ram_port_arbiter.
interface ram_port_arbiter_if #(parameter int G = 18);
  logic         p0_req_i, p0_we_i, p0_byte_i;
  logic [G-1:0] p0_addr_i;
  logic [31:0]  p0_wdata_i;
  logic         p0_ack_o, p0_err_o;
  logic [31:0]  p0_rdata_o;

  logic         p1_req_i, p1_we_i, p1_byte_i;
  logic [G-1:0] p1_addr_i;
  logic [31:0]  p1_wdata_i;
  logic         p1_ack_o, p1_err_o;
  logic [31:0]  p1_rdata_o;

  logic [G-1:0] ram_addr_o;
  logic [31:0]  ram_wdata_o;
  logic         ram_en_o, ram_byte_o;
  logic [31:0]  ram_rdata_i;
  logic         busy_o;

  modport slave (
    input  p0_req_i, p0_we_i, p0_byte_i, p0_addr_i, p0_wdata_i,
    input  p1_req_i, p1_we_i, p1_byte_i, p1_addr_i, p1_wdata_i,
    input  ram_rdata_i,
    output p0_ack_o, p0_err_o, p0_rdata_o,
    output p1_ack_o, p1_err_o, p1_rdata_o,
    output ram_addr_o, ram_wdata_o, ram_en_o, ram_byte_o, busy_o
  );

  modport master (
    output p0_req_i, p0_we_i, p0_byte_i, p0_addr_i, p0_wdata_i,
    output p1_req_i, p1_we_i, p1_byte_i, p1_addr_i, p1_wdata_i,
    output ram_rdata_i,
    input  p0_ack_o, p0_err_o, p0_rdata_o,
    input  p1_ack_o, p1_err_o, p1_rdata_o,
    input  ram_addr_o, ram_wdata_o, ram_en_o, ram_byte_o, busy_o
  );
endinterface

// File: rtl/ram_arb_rr_picker.sv
// Two-way round-robin picker: on a tie the port that did not win last time wins.
module ram_arb_rr_picker
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  output logic       grant_valid,
  output port_id_t   grant_id
);
  always_comb begin
    grant_valid = |req;
    grant_id    = port_id_t'(req[1]);
    if (&req) grant_id = ~last_grant;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one byte-addressable RAM between the CPU LSU (port 0) and loader/DMA (port 1).
// Build option: RAM_ARB_ALIGN_CHECK_EN enables misaligned-word rejection with err.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int G = RAM_G
)(
  input  logic               CLK,
  input  logic               RST,
  ram_port_arbiter_if.slave  bus
);
  arb_state_t state, state_nx;
  port_id_t   last_grant, win_q, grant_id;
  logic       grant_valid;
  logic       reject;
  logic [NUM_PORTS-1:0]         req, ack, err_q;
  logic [NUM_PORTS-1:0][DW-1:0] rdata_q;
  logic [DW-1:0] rd_val;
  ram_req_t   in_req [NUM_PORTS];
  ram_req_t   req_q;

  assign req = {bus.p1_req_i, bus.p0_req_i};

  always_comb begin
    in_req[0] = '{we: bus.p0_we_i, bmode: bus.p0_byte_i, addr: bus.p0_addr_i, wdata: bus.p0_wdata_i};
    in_req[1] = '{we: bus.p1_we_i, bmode: bus.p1_byte_i, addr: bus.p1_addr_i, wdata: bus.p1_wdata_i};
  end

  ram_arb_rr_picker u_pick (
    .req         (req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_valid) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch is only loaded on a grant, so the RAM bus holds its last value when idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      win_q      <= 1'b0;
      req_q      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant_valid) begin
        last_grant <= grant_id;
        win_q      <= grant_id;
        req_q      <= in_req[grant_id];
      end
    end
  end

`ifdef RAM_ARB_ALIGN_CHECK_EN
  assign reject = !req_q.bmode && (req_q.addr[$clog2(WORD_BYTES)-1:0] != '0);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    rd_val = bus.ram_rdata_i;
    if (req_q.we || reject) rd_val = '0;
    else if (req_q.bmode)   rd_val = {24'b0, bus.ram_rdata_i[7:0]};
  end

  // Per-port response registers: written at the end of ACCESS, held until the next ack.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    always_ff @(posedge CLK) begin
      if (RST) begin
        rdata_q[p] <= '0;
        err_q[p]   <= 1'b0;
      end else if (state == ACCESS && win_q == port_id_t'(p)) begin
        rdata_q[p] <= rd_val;
        err_q[p]   <= reject;
      end
    end
    assign ack[p] = (state == RESP) && (win_q == port_id_t'(p));
  end

  assign bus.p0_ack_o   = ack[0];
  assign bus.p0_rdata_o = rdata_q[0];
  assign bus.p0_err_o   = err_q[0];
  assign bus.p1_ack_o   = ack[1];
  assign bus.p1_rdata_o = rdata_q[1];
  assign bus.p1_err_o   = err_q[1];

  assign bus.ram_addr_o  = req_q.addr;
  assign bus.ram_wdata_o = req_q.wdata;
  assign bus.ram_byte_o  = req_q.bmode;
  assign bus.ram_en_o    = (state == ACCESS) && req_q.we && !reject;
  assign bus.busy_o      = (state != IDLE);
endmodule
